// File: rtl/trap_ctrl_if.sv
// Trap sequencer outbound bus: the CSR write port and the IFU redirect.
//   csr_we/csr_waddr/csr_wdata : one CSR write per cycle
//   jump_req/jump_pc           : single-cycle redirect pulse and its target
// master = trap_ctrl (driver), slave = CSR file / IFU (receiver).
interface trap_ctrl_if #(parameter int XLEN = 32);
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            jump_req;
  logic [XLEN-1:0] jump_pc;

  modport master (output csr_we, csr_waddr, csr_wdata, jump_req, jump_pc);
  modport slave  (input  csr_we, csr_waddr, csr_wdata, jump_req, jump_pc);
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer.
// Arbitrates masked interrupt lines and ecall/ebreak/illegal/mret from decode,
// then writes mepc, mcause, mtval, mstatus one CSR per cycle and redirects the IFU.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   irq_i                level interrupt requests (bit0 MSI, bit1 MTI, bit2 MEI, locals above)
//   exc_*_i, mret_i      decoded exception / return events
//   inst_i, pc_i         instruction word and PC in decode
//   csr_*_i              current mtvec/mepc/mstatus/mie
//   ex_busy_i            multi-cycle mul/div in flight
//   ex_cancel_o          abort mul/div (mirror of flushreq_o[1])
//   mip_o                registered pending bits at their mip positions
//   stallreq_o           pipeline stall while a sequence runs
//   flushreq_o           [0] sync, [1] async with cancel, [2] async without cancel
//   bus                  CSR write port and redirect (trap_ctrl_if.master)
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int NUM_IRQ     = 3,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               exc_ecall_i,
  input  logic               exc_ebreak_i,
  input  logic               exc_illegal_i,
  input  logic               mret_i,
  input  logic [XLEN-1:0]    inst_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    csr_mtvec_i,
  input  logic [XLEN-1:0]    csr_mepc_i,
  input  logic [XLEN-1:0]    csr_mstatus_i,
  input  logic [XLEN-1:0]    csr_mie_i,
  input  logic               ex_busy_i,
  output logic               ex_cancel_o,
  output logic [XLEN-1:0]    mip_o,
  output logic               stallreq_o,
  output logic [2:0]         flushreq_o,
  trap_ctrl_if.master        bus
);
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  typedef enum logic [2:0] {IDLE, MEPC, MCAUSE, MTVAL, MSTATUS, MRET_MS, JUMP} state_t;

  // Line index -> exception code: MSI 3, MTI 7, MEI 11, local k -> 16+k-3.
  function automatic logic [4:0] irq_code(input logic [4:0] k);
    case (k)
      5'd0:    return 5'd3;
      5'd1:    return 5'd7;
      5'd2:    return 5'd11;
      default: return k + 5'd13;
    endcase
  endfunction

  state_t          state, nxt;
  logic [XLEN-1:0] epc_q, tval_q;
  logic [4:0]      code_q;
  logic            int_q, mret_q;

  logic [NUM_IRQ-1:0] irq_en;
  logic               int_hit;
  logic [4:0]         int_idx;
  logic [XLEN-1:0]    mip_d;

  logic            load, acc_int, acc_mret;
  logic [4:0]      acc_code;
  logic [XLEN-1:0] acc_epc, acc_tval;
  logic [2:0]      flush_d;
  logic            we_d, jump_d;
  logic [11:0]     waddr_d;
  logic [XLEN-1:0] wdata_d, jpc_d, base, ms_trap, ms_mret;

  logic            we_q, jump_q;
  logic [11:0]     waddr_q;
  logic [XLEN-1:0] wdata_q, jpc_q;

  // Only the mie bits at interrupt code positions take part in enabling.
  logic unused_mie;
  assign unused_mie = ^csr_mie_i;

  always_comb begin
    irq_en = '0;
    mip_d  = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      irq_en[k]                = irq_i[k] & csr_mie_i[irq_code(5'(k))] & csr_mstatus_i[3];
      mip_d[irq_code(5'(k))]   = irq_i[k];
    end
  end

  // Later assignments win: locals ascending (lowest last), then MTI, MSI, MEI.
  always_comb begin
    int_hit = |irq_en;
    int_idx = '0;
    for (int k = NUM_IRQ-1; k >= 3; k--)
      if (irq_en[k]) int_idx = 5'(k);
    if (irq_en[1]) int_idx = 5'd1;
    if (irq_en[0]) int_idx = 5'd0;
    if (irq_en[2]) int_idx = 5'd2;
  end

  always_comb begin
    base    = {csr_mtvec_i[XLEN-1:2], 2'b00};
    ms_trap = csr_mstatus_i;
    ms_trap[12:11] = 2'b11;
    ms_trap[7]     = csr_mstatus_i[3];
    ms_trap[3]     = 1'b0;
    ms_mret = csr_mstatus_i;
    ms_mret[12:11] = 2'b11;
    ms_mret[7]     = 1'b1;
    ms_mret[3]     = csr_mstatus_i[7];
  end

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    acc_int  = 1'b0;
    acc_mret = 1'b0;
    acc_code = '0;
    acc_tval = '0;
    acc_epc  = pc_i + XLEN'(4);
    flush_d  = '0;
    we_d     = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
    jump_d   = 1'b0;
    jpc_d    = '0;
    case (state)
      IDLE: begin
        if (int_hit) begin
          // Interrupts may preempt a busy mul/div; its instruction is replayed.
          load     = 1'b1;
          acc_int  = 1'b1;
          acc_code = irq_code(int_idx);
          acc_epc  = ex_busy_i ? pc_i - XLEN'(4) : pc_i;
          flush_d  = ex_busy_i ? 3'b010 : 3'b100;
          nxt      = MEPC;
        end else if (!ex_busy_i) begin
          if (exc_ebreak_i) begin
            load = 1'b1; acc_code = 5'd3; acc_tval = pc_i;
          end else if (exc_illegal_i) begin
            load = 1'b1; acc_code = 5'd2; acc_tval = inst_i;
          end else if (exc_ecall_i) begin
            load = 1'b1; acc_code = 5'd11;
          end else if (mret_i) begin
            load = 1'b1; acc_mret = 1'b1;
          end
          if (load) begin
            flush_d = 3'b001;
            nxt     = acc_mret ? MRET_MS : MEPC;
          end
        end
      end
      MEPC:    begin we_d = 1'b1; waddr_d = A_MEPC;  wdata_d = epc_q;  nxt = MCAUSE;  end
      MCAUSE:  begin
        we_d = 1'b1; waddr_d = A_MCAUSE;
        wdata_d[XLEN-1] = int_q;
        wdata_d[4:0]    = code_q;
        nxt = MTVAL;
      end
      MTVAL:   begin we_d = 1'b1; waddr_d = A_MTVAL;   wdata_d = tval_q;  nxt = MSTATUS; end
      MSTATUS: begin we_d = 1'b1; waddr_d = A_MSTATUS; wdata_d = ms_trap; nxt = JUMP;    end
      MRET_MS: begin we_d = 1'b1; waddr_d = A_MSTATUS; wdata_d = ms_mret; nxt = JUMP;    end
      JUMP: begin
        jump_d = 1'b1;
        if (mret_q) jpc_d = csr_mepc_i;
        else jpc_d = base + ((VECTORED_EN && csr_mtvec_i[1:0] == 2'b01 && int_q)
                             ? XLEN'({code_q, 2'b00}) : '0);
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign stallreq_o = (state != IDLE) | (nxt != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      epc_q      <= '0;
      tval_q     <= '0;
      code_q     <= '0;
      int_q      <= 1'b0;
      mret_q     <= 1'b0;
      flushreq_o <= '0;
      mip_o      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      jump_q     <= 1'b0;
      jpc_q      <= '0;
    end else begin
      state      <= nxt;
      flushreq_o <= flush_d;
      mip_o      <= mip_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      jump_q     <= jump_d;
      jpc_q      <= jpc_d;
      if (load) begin
        epc_q  <= acc_epc;
        tval_q <= acc_tval;
        code_q <= acc_code;
        int_q  <= acc_int;
        mret_q <= acc_mret;
      end
    end
  end

  assign ex_cancel_o   = flushreq_o[1];
  assign bus.csr_we    = we_q;
  assign bus.csr_waddr = waddr_q;
  assign bus.csr_wdata = wdata_q;
  assign bus.jump_req  = jump_q;
  assign bus.jump_pc   = jpc_q;
endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  irq = '0;
  logic        ecall = 0, ebreak = 0, illegal = 0, mret = 0, busy = 0;
  logic [31:0] inst = '0, pc = '0, mtvec = '0, mepc = '0, ms = '0, mie = '0;
  logic        cancel, stall;
  logic [31:0] mip;
  logic [2:0]  flush;
  int          total = 0, bad = 0;

  trap_ctrl_if #(.XLEN(32)) bus ();

  trap_ctrl #(.XLEN(32), .NUM_IRQ(3), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq),
    .exc_ecall_i(ecall), .exc_ebreak_i(ebreak), .exc_illegal_i(illegal), .mret_i(mret),
    .inst_i(inst), .pc_i(pc), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
    .csr_mstatus_i(ms), .csr_mie_i(mie), .ex_busy_i(busy),
    .ex_cancel_o(cancel), .mip_o(mip), .stallreq_o(stall), .flushreq_o(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  irq;
    logic        busy, ecall, ebreak, illegal, mret;
    logic [31:0] pc, inst, mtvec, ms, mie, mepc;
  } in_t;
  typedef struct packed {
    logic [1:0]  kind;   // 0 none, 1 trap, 2 mret
    logic [2:0]  flush;
    logic [31:0] mepc, mcause, mtval, mstatus, jpc;
  } exp_t;
  typedef struct packed { in_t s; exp_t e; } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic int code_of(input int k);
    return (k < 3) ? k * 4 + 3 : 16 + k - 3;
  endfunction

  function automatic logic [31:0] mip_of(input logic [2:0] r);
    logic [31:0] m = '0;
    for (int k = 0; k < 3; k++) if (r[k]) m = m | (32'd1 << code_of(k));
    return m;
  endfunction

  // Reference: pick the event from the accept rules, then compute CSR values and target.
  function automatic exp_t model(input in_t s);
    exp_t e = '0;
    int   ord[3] = '{2, 0, 1};
    int   win = -1;
    int   code = 0;
    logic [31:0] b = s.mtvec & ~32'd3;
    for (int i = 0; i < 3; i++)
      if (win < 0 && s.irq[ord[i]] && s.mie[code_of(ord[i])] && s.ms[3]) win = ord[i];
    if (win >= 0) begin
      e.kind = 1; code = code_of(win);
      e.mcause = 32'h8000_0000 | code;
      e.mepc   = s.busy ? s.pc - 4 : s.pc;
      e.flush  = s.busy ? 3'b010 : 3'b100;
      e.jpc    = (s.mtvec[1:0] == 2'b01) ? b + 4 * code : b;
    end else if (!s.busy) begin
      e.mepc = s.pc + 4; e.jpc = b; e.flush = 3'b001;
      if (s.ebreak)       begin e.kind = 1; e.mcause = 3;  e.mtval = s.pc;   end
      else if (s.illegal) begin e.kind = 1; e.mcause = 2;  e.mtval = s.inst; end
      else if (s.ecall)   begin e.kind = 1; e.mcause = 11; end
      else if (s.mret)    begin e.kind = 2; e.mepc = 0; e.jpc = s.mepc; end
      else e = '0;
    end
    if (e.kind == 1) e.mstatus = (s.ms & ~32'h1888) | 32'h1800 | (s.ms[3] ? 32'h80 : 32'h0);
    if (e.kind == 2) e.mstatus = (s.ms & ~32'h1888) | 32'h1880 | (s.ms[7] ? 32'h8 : 32'h0);
    return e;
  endfunction

  task automatic drive(input in_t s);
    irq = s.irq; busy = s.busy; ecall = s.ecall; ebreak = s.ebreak;
    illegal = s.illegal; mret = s.mret; pc = s.pc; inst = s.inst;
    mtvec = s.mtvec; ms = s.ms; mie = s.mie; mepc = s.mepc;
  endtask

  task automatic clear_events();
    irq = '0; busy = 0; ecall = 0; ebreak = 0; illegal = 0; mret = 0;
  endtask

  // Called at a negedge with the DUT idle; applies one event cycle and checks the whole sequence.
  task automatic run(input in_t s, input exp_t e, input string tag);
    logic [31:0] adr [4];
    logic [31:0] dat [4];
    int n;
    drive(s);
    #1 chk({tag, ":stall_accept"}, {31'd0, stall}, {31'd0, e.kind != 0});
    @(negedge clk);
    chk({tag, ":flush"}, {29'd0, flush}, {29'd0, e.flush});
    chk({tag, ":cancel"}, {31'd0, cancel}, {31'd0, e.flush[1]});
    chk({tag, ":mip"}, mip, mip_of(s.irq));
    chk({tag, ":we_idle"}, {31'd0, bus.csr_we}, 32'd0);
    clear_events();
    n = 0;
    if (e.kind == 1) begin
      adr = '{32'h341, 32'h342, 32'h343, 32'h300};
      dat = '{e.mepc, e.mcause, e.mtval, e.mstatus};
      n = 4;
    end else if (e.kind == 2) begin
      adr = '{32'h300, 32'h0, 32'h0, 32'h0};
      dat = '{e.mstatus, 32'h0, 32'h0, 32'h0};
      n = 1;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ":we"}, {31'd0, bus.csr_we}, 32'd1);
      chk({tag, ":waddr"}, {20'd0, bus.csr_waddr}, adr[i]);
      chk({tag, ":wdata"}, bus.csr_wdata, dat[i]);
      chk({tag, ":nojump"}, {31'd0, bus.jump_req}, 32'd0);
      chk({tag, ":stall_seq"}, {31'd0, stall}, 32'd1);
    end
    if (n > 0) begin
      @(negedge clk);
      chk({tag, ":jump"}, {31'd0, bus.jump_req}, 32'd1);
      chk({tag, ":jump_pc"}, bus.jump_pc, e.jpc);
      chk({tag, ":we_end"}, {31'd0, bus.csr_we}, 32'd0);
      chk({tag, ":stall_end"}, {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk({tag, ":jump_pulse"}, {31'd0, bus.jump_req}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":we"}, {31'd0, bus.csr_we}, 32'd0);
    chk({tag, ":waddr"}, {20'd0, bus.csr_waddr}, 32'd0);
    chk({tag, ":wdata"}, bus.csr_wdata, 32'd0);
    chk({tag, ":jump"}, {31'd0, bus.jump_req}, 32'd0);
    chk({tag, ":jump_pc"}, bus.jump_pc, 32'd0);
    chk({tag, ":flush"}, {29'd0, flush}, 32'd0);
    chk({tag, ":mip"}, mip, 32'd0);
    chk({tag, ":stall"}, {31'd0, stall}, 32'd0);
  endtask

  vec_t tbl [13];
  in_t  rs;

  initial begin
    //            irq    busy ecl ebk ill mrt pc          inst          mtvec         ms            mie         mepc
    tbl[0]  = '{'{3'b010, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h13,       32'h1000, 32'h8,    32'h80,  32'h0},
                '{2'd1, 3'b100, 32'h100, 32'h8000_0007, 32'h0, 32'h1880, 32'h1000}};
    tbl[1]  = '{'{3'b010, 1'b1,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h13,       32'h1000, 32'h8,    32'h80,  32'h0},
                '{2'd1, 3'b010, 32'hFC, 32'h8000_0007, 32'h0, 32'h1880, 32'h1000}};
    tbl[2]  = '{'{3'b110, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h13,       32'h201,  32'h8,    32'h880, 32'h0},
                '{2'd1, 3'b100, 32'h100, 32'h8000_000B, 32'h0, 32'h1880, 32'h22C}};
    tbl[3]  = '{'{3'b000, 1'b0,1'b0,1'b0,1'b1,1'b0, 32'h40,  32'hFFFF_FFFF, 32'h201, 32'h8,    32'h0,   32'h0},
                '{2'd1, 3'b001, 32'h44, 32'h2, 32'hFFFF_FFFF, 32'h1880, 32'h200}};
    tbl[4]  = '{'{3'b000, 1'b0,1'b0,1'b0,1'b0,1'b1, 32'h60,  32'h30200073, 32'h201,  32'h1880, 32'h0,   32'h44},
                '{2'd2, 3'b001, 32'h0, 32'h0, 32'h0, 32'h1888, 32'h44}};
    tbl[5]  = '{'{3'b000, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'h80,  32'h00100073, 32'h1001, 32'h22,   32'h0,   32'h0},
                '{2'd1, 3'b001, 32'h84, 32'h3, 32'h80, 32'h1822, 32'h1000}};
    tbl[6]  = '{'{3'b111, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h100, 32'h13,       32'h1000, 32'h0,    32'h888, 32'h0},
                '{2'd0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    tbl[7]  = '{'{3'b001, 1'b0,1'b1,1'b0,1'b0,1'b0, 32'h20,  32'h73,       32'h400,  32'h8,    32'h80,  32'h0},
                '{2'd1, 3'b001, 32'h24, 32'hB, 32'h0, 32'h1880, 32'h400}};
    tbl[8]  = '{'{3'b000, 1'b1,1'b1,1'b0,1'b0,1'b0, 32'h20,  32'h73,       32'h400,  32'h8,    32'h0,   32'h0},
                '{2'd0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    tbl[9]  = '{'{3'b001, 1'b1,1'b1,1'b0,1'b0,1'b0, 32'h100, 32'h73,       32'h301,  32'h8,    32'h8,   32'h0},
                '{2'd1, 3'b010, 32'hFC, 32'h8000_0003, 32'h0, 32'h1880, 32'h30C}};
    tbl[10] = '{'{3'b000, 1'b0,1'b1,1'b1,1'b1,1'b0, 32'h10,  32'h1234,     32'h200,  32'h8,    32'h0,   32'h0},
                '{2'd1, 3'b001, 32'h14, 32'h3, 32'h10, 32'h1880, 32'h200}};
    tbl[11] = '{'{3'b000, 1'b0,1'b1,1'b0,1'b0,1'b1, 32'h30,  32'h73,       32'h200,  32'h8,    32'h0,   32'h0},
                '{2'd1, 3'b001, 32'h34, 32'hB, 32'h0, 32'h1880, 32'h200}};
    tbl[12] = '{'{3'b000, 1'b1,1'b0,1'b0,1'b0,1'b1, 32'h30,  32'h30200073, 32'h200,  32'h8,    32'h0,   32'h44},
                '{2'd0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));

    // ecall held while mul/div busy for 3 cycles, then accepted
    rs = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h73, 32'h200, 32'h8, 32'h0, 32'h0};
    drive(rs);
    for (int i = 0; i < 3; i++) begin
      #1 chk("busy_ecall:stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("busy_ecall:flush", {29'd0, flush}, 32'd0);
    end
    rs.busy = 1'b0;
    run(rs, '{2'd1, 3'b001, 32'h44, 32'hB, 32'h0, 32'h1880, 32'h200}, "busy_ecall");

    // Reset asserted while the FSM sits in MCAUSE drops the trap
    drive(tbl[0].s);
    @(negedge clk);
    clear_events();
    @(negedge clk);
    chk("midrst:mepc_we", {31'd0, bus.csr_we}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("midrst:no_we", {31'd0, bus.csr_we}, 32'd0);
      chk("midrst:no_jump", {31'd0, bus.jump_req}, 32'd0);
    end

    // Randomized trials against the reference model
    for (int t = 0; t < 300; t++) begin
      rs.irq     = 3'($urandom);
      rs.busy    = ($urandom_range(0, 3) == 0);
      rs.ecall   = ($urandom_range(0, 3) == 0);
      rs.ebreak  = ($urandom_range(0, 3) == 0);
      rs.illegal = ($urandom_range(0, 3) == 0);
      rs.mret    = ($urandom_range(0, 2) == 0);
      rs.pc      = $urandom & ~32'd3;
      rs.inst    = $urandom;
      rs.mtvec   = $urandom;
      rs.ms      = $urandom;
      rs.mie     = $urandom;
      rs.mepc    = $urandom;
      if ($urandom_range(0, 1) == 0) rs.irq = '0;
      run(rs, model(rs), $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
